pauli_gate_pipe: RTL and testbench

Parametrised, multiplier-free single-qubit gate unit. Applies one of I, X, Y, Z, S, S†, or global −1 to a qubit amplitude pair (α, β), selected per transaction. Two-stage pipeline with valid/ready backpressure, saturating negation, tag pass-through and a transaction counter. It replaces the fixed X-swap stage in the QFT datapath wherever a Pauli or phase gate is needed.

---
 rtl/pauli_gate_pipe.sv | 166 ++++++++++++++++
 tb/tb_pauli_gate_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pauli_gate_pipe.sv
// Multiplier-free single-qubit gate unit: I/X/Y/Z/S/S-dagger/NEG on (alpha, beta).
// S1 registers routed components plus negate flags; S2 applies saturating negation.
module pauli_gate_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic signed [WIDTH-1:0] alpha_r,
  input  logic signed [WIDTH-1:0] alpha_i,
  input  logic signed [WIDTH-1:0] beta_r,
  input  logic signed [WIDTH-1:0] beta_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] new_alpha_r,
  output logic signed [WIDTH-1:0] new_alpha_i,
  output logic signed [WIDTH-1:0] new_beta_r,
  output logic signed [WIDTH-1:0] new_beta_i,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_sat,
  output logic                    out_err,
  output logic [CNT_W-1:0]        gate_count
);

  typedef enum logic [2:0] {
    OP_I   = 3'd0,
    OP_X   = 3'd1,
    OP_Y   = 3'd2,
    OP_Z   = 3'd3,
    OP_S   = 3'd4,
    OP_SDG = 3'd5,
    OP_NEG = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  logic s1_valid, s2_valid;
  logic s1_load, s2_load, in_fire;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Routing: {ar, ai, br, bi} output slots, negate flags in the same bit order (3..0)
  logic signed [WIDTH-1:0] rt_ar, rt_ai, rt_br, rt_bi;
  logic [3:0]              rt_neg;
  logic                    rt_err;

  always_comb begin
    rt_ar  = alpha_r;
    rt_ai  = alpha_i;
    rt_br  = beta_r;
    rt_bi  = beta_i;
    rt_neg = 4'b0000;
    rt_err = 1'b0;
    case (op_e'(in_op))
      OP_I: ;
      OP_X: begin
        rt_ar = beta_r;  rt_ai = beta_i;
        rt_br = alpha_r; rt_bi = alpha_i;
      end
      OP_Y: begin
        rt_ar = beta_i;  rt_ai = beta_r;
        rt_br = alpha_i; rt_bi = alpha_r;
        rt_neg = 4'b0110;
      end
      OP_Z:   rt_neg = 4'b0011;
      OP_S: begin
        rt_br = beta_i; rt_bi = beta_r;
        rt_neg = 4'b0010;
      end
      OP_SDG: begin
        rt_br = beta_i; rt_bi = beta_r;
        rt_neg = 4'b0001;
      end
      OP_NEG: rt_neg = 4'b1111;
      OP_RSV: rt_err = 1'b1;
      default: ;
    endcase
  end

  logic signed [WIDTH-1:0] s1_ar, s1_ai, s1_br, s1_bi;
  logic [3:0]              s1_neg;
  logic [TAG_W-1:0]        s1_tag;
  logic                    s1_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
      s1_neg   <= '0;
      s1_tag   <= '0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ar  <= rt_ar;
        s1_ai  <= rt_ai;
        s1_br  <= rt_br;
        s1_bi  <= rt_bi;
        s1_neg <= rt_neg;
        s1_tag <= in_tag;
        s1_err <= rt_err;
      end
    end
  end

  function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] x);
    return (x == MIN_VAL) ? MAX_VAL : -x;
  endfunction

  logic signed [WIDTH-1:0] n_ar, n_ai, n_br, n_bi;
  logic [3:0]              n_sat;

  always_comb begin
    n_ar  = s1_neg[3] ? sat_neg(s1_ar) : s1_ar;
    n_ai  = s1_neg[2] ? sat_neg(s1_ai) : s1_ai;
    n_br  = s1_neg[1] ? sat_neg(s1_br) : s1_br;
    n_bi  = s1_neg[0] ? sat_neg(s1_bi) : s1_bi;
    n_sat = s1_neg & {s1_ar == MIN_VAL, s1_ai == MIN_VAL, s1_br == MIN_VAL, s1_bi == MIN_VAL};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      new_alpha_r <= '0;
      new_alpha_i <= '0;
      new_beta_r  <= '0;
      new_beta_i  <= '0;
      out_tag     <= '0;
      out_sat     <= 1'b0;
      out_err     <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        new_alpha_r <= n_ar;
        new_alpha_i <= n_ai;
        new_beta_r  <= n_br;
        new_beta_i  <= n_bi;
        out_tag     <= s1_tag;
        out_sat     <= |n_sat;
        out_err     <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gate_count <= '0;
    else if (in_fire)
      gate_count <= gate_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_pauli_gate_pipe.sv
// Scoreboard bench for pauli_gate_pipe: expected results queued on accept, compared on output.
module tb_pauli_gate_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_sat, out_err;
  logic [2:0] in_op = '0;
  logic [3:0] in_tag = '0, out_tag;
  logic signed [15:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic signed [15:0] na_r, na_i, nb_r, nb_i;
  logic [31:0] gate_count;

  logic w_valid = 1'b0, w_in_ready, w_out_valid, w_out_sat, w_out_err;
  logic [15:0] w_na_r, w_na_i, w_nb_r, w_nb_i;
  logic [3:0] w_tag, w_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pauli_gate_pipe #(.WIDTH(16), .TAG_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_tag(in_tag),
    .alpha_r(a_r), .alpha_i(a_i), .beta_r(b_r), .beta_i(b_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .new_alpha_r(na_r), .new_alpha_i(na_i), .new_beta_r(nb_r), .new_beta_i(nb_i),
    .out_tag(out_tag), .out_sat(out_sat), .out_err(out_err), .gate_count(gate_count)
  );

  pauli_gate_pipe #(.WIDTH(16), .TAG_W(4), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_in_ready),
    .in_op(3'd0), .in_tag(4'd0),
    .alpha_r(16'sd1), .alpha_i(16'sd2), .beta_r(16'sd3), .beta_i(16'sd4),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .new_alpha_r(w_na_r), .new_alpha_i(w_na_i), .new_beta_r(w_nb_r), .new_beta_i(w_nb_i),
    .out_tag(w_tag), .out_sat(w_out_sat), .out_err(w_out_err), .gate_count(w_count)
  );

  typedef struct {
    logic signed [15:0] ar, ai, br, bi;
    logic [3:0] tag;
    logic sat, err;
  } exp_t;

  exp_t sb[$];

  function automatic logic signed [15:0] ng(input logic signed [15:0] x, inout logic s);
    if (x == -16'sd32768) begin
      s = 1'b1;
      return 16'sd32767;
    end
    return -x;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [3:0] tag,
                                 input logic signed [15:0] ar, ai, br, bi);
    exp_t e;
    e.tag = tag; e.sat = 1'b0; e.err = 1'b0;
    e.ar = ar; e.ai = ai; e.br = br; e.bi = bi;
    case (op)
      3'd1: begin e.ar = br; e.ai = bi; e.br = ar; e.bi = ai; end
      3'd2: begin e.ar = bi; e.ai = ng(br, e.sat); e.br = ng(ai, e.sat); e.bi = ar; end
      3'd3: begin e.br = ng(br, e.sat); e.bi = ng(bi, e.sat); end
      3'd4: begin e.br = ng(bi, e.sat); e.bi = br; end
      3'd5: begin e.br = bi; e.bi = ng(br, e.sat); end
      3'd6: begin
        e.ar = ng(ar, e.sat); e.ai = ng(ai, e.sat);
        e.br = ng(br, e.sat); e.bi = ng(bi, e.sat);
      end
      3'd7: e.err = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: push on input transfer, pop/compare on output transfer, check stall stability
  exp_t got, want;
  logic stall_prev = 1'b0;
  logic signed [15:0] h_ar, h_ai, h_br, h_bi;
  logic [3:0] h_tag;
  logic h_sat, h_err;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)
        sb.push_back(model(in_op, in_tag, a_r, a_i, b_r, b_i));
      if (stall_prev && out_valid) begin
        checks++;
        if ({na_r, na_i, nb_r, nb_i, out_tag, out_sat, out_err} !==
            {h_ar, h_ai, h_br, h_bi, h_tag, h_sat, h_err}) begin
          errors++;
          $display("FAIL stall_stable: got %0d %0d %0d %0d tag %0d, held %0d %0d %0d %0d tag %0d",
                   na_r, na_i, nb_r, nb_i, out_tag, h_ar, h_ai, h_br, h_bi, h_tag);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: tag %0d emitted, none expected", out_tag);
        end else begin
          want = sb.pop_front();
          got.ar = na_r; got.ai = na_i; got.br = nb_r; got.bi = nb_i;
          got.tag = out_tag; got.sat = out_sat; got.err = out_err;
          if (got !== want) begin
            errors++;
            $display("FAIL result tag %0d: got (%0d,%0d)(%0d,%0d) sat %0d err %0d tag %0d, expected (%0d,%0d)(%0d,%0d) sat %0d err %0d tag %0d",
                     want.tag, got.ar, got.ai, got.br, got.bi, got.sat, got.err, got.tag,
                     want.ar, want.ai, want.br, want.bi, want.sat, want.err, want.tag);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      {h_ar, h_ai, h_br, h_bi, h_tag, h_sat, h_err} = {na_r, na_i, nb_r, nb_i, out_tag, out_sat, out_err};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] tag,
                      input logic signed [15:0] ar, ai, br, bi);
    int unsigned n = 0;
    in_valid = 1'b1; in_op = op; in_tag = tag;
    a_r = ar; a_i = ai; b_r = br; b_i = bi;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready %0b, required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, in_ready, gate_count} !== {1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid %0b in_ready %0b gate_count %0d, required 0 1 0",
               out_valid, in_ready, gate_count);
    end
    checks++;
    if ({na_r, na_i, nb_r, nb_i, out_tag, out_sat, out_err} !== '0) begin
      errors++;
      $display("FAIL reset_data: %0d %0d %0d %0d tag %0d sat %0b err %0b, required all 0",
               na_r, na_i, nb_r, nb_i, out_tag, out_sat, out_err);
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(3'd1, 4'd5, 16'sd100, -16'sd200, 16'sd300, 16'sd400);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid %0b one edge after accept, required 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || {na_r, na_i, nb_r, nb_i, out_tag} !==
        {16'sd300, 16'sd400, 16'sd100, -16'sd200, 4'd5}) begin
      errors++;
      $display("FAIL latency_x: valid %0b (%0d,%0d)(%0d,%0d) tag %0d, required 1 (300,400)(100,-200) tag 5",
               out_valid, na_r, na_i, nb_r, nb_i, out_tag);
    end
    drain();
  endtask

  task automatic test_ops();
    out_ready = 1'b1;
    send(3'd2, 4'd1, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
    send(3'd4, 4'd2, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
    send(3'd5, 4'd3, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
    send(3'd6, 4'd4, -16'sd32768, 16'sd5, 16'sd0, 16'sd32767);
    send(3'd3, 4'd5, 16'sd1, 16'sd2, -16'sd32768, 16'sd0);
    send(3'd7, 4'd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10);
    send(3'd0, 4'd7, -16'sd32768, 16'sd11, 16'sd12, -16'sd13);
    send(3'd6, 4'd8, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
    send(3'd2, 4'd9, 16'sd5, -16'sd32768, 16'sd6, 16'sd7);
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 10; i++)
        send(3'(i % 8), 4'(i), 16'(i * 3), 16'(-i), 16'(i + 100), 16'(i * 7));
      begin
        int unsigned n = 0;
        @(posedge clk); #2;
        while (!out_valid && n < 20) begin
          @(posedge clk); #2;
          n++;
        end
        for (int k = 0; k < 10; k++) begin
          checks++;
          if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_valid beat %0d: out_valid %0b, required 1", k, out_valid);
          end
          @(posedge clk); #2;
        end
      end
    join
    drain();
    checks++;
    if (gate_count !== 32'd10) begin
      errors++;
      $display("FAIL stream_count: gate_count %0d, required 10", gate_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 8; i++)
        send(3'(7 - i), 4'(i + 3), 16'(i * 11), 16'(i - 4), 16'(-i * 5), 16'(i + 20));
      begin
        repeat (3) @(posedge clk);
        #3 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #3;
          checks++;
          if (sb.size() > 2 || (sb.size() == 2 && in_ready !== 1'b0)) begin
            errors++;
            $display("FAIL stall_inflight: in_flight %0d in_ready %0b, required <=2 and in_ready 0 when full",
                     sb.size(), in_ready);
          end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL release_ready: in_ready %0b, required 1", in_ready);
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(3'd1, 4'd12, 16'sd1, 16'sd1, 16'sd1, 16'sd1);
    send(3'd3, 4'd13, 16'sd2, 16'sd2, 16'sd2, 16'sd2);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({out_valid, gate_count} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL midflight_reset: out_valid %0b gate_count %0d, required 0 0", out_valid, gate_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_discard: out_valid %0b, required 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    int unsigned acc = 0;
    int unsigned n = 0;
    w_valid = 1'b1;
    while (acc < 17 && n < 100) begin
      @(negedge clk);
      if (w_in_ready) acc++;
      @(posedge clk); #1;
      n++;
    end
    w_valid = 1'b0;
    checks++;
    if (w_count !== 4'd1) begin
      errors++;
      $display("FAIL count_wrap: gate_count %0d after %0d accepts, required 1", w_count, acc);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
